// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the two requesters, decode, and the register file write port.
// The slave modport is the arbiter side; master is the side that drives requests.
interface regfile_wb_arbiter_if;
    logic        req_a_valid;
    logic [4:0]  req_a_dest;
    logic [31:0] req_a_data;
    logic        req_a_ready;
    logic        req_b_valid;
    logic [4:0]  req_b_dest;
    logic [31:0] req_b_data;
    logic        req_b_ready;
    logic        rsv_valid;
    logic [4:0]  rsv_dest;
    logic [4:0]  src_one;
    logic [4:0]  src_two;
    logic        busy_one;
    logic        busy_two;
    logic        rf_write_enable;
    logic [4:0]  rf_dest;
    logic [31:0] rf_data_in;
    logic        idle;

    modport slave (
        input  req_a_valid, req_a_dest, req_a_data,
        input  req_b_valid, req_b_dest, req_b_data,
        input  rsv_valid, rsv_dest, src_one, src_two,
        output req_a_ready, req_b_ready, busy_one, busy_two,
        output rf_write_enable, rf_dest, rf_data_in, idle
    );

    modport master (
        output req_a_valid, req_a_dest, req_a_data,
        output req_b_valid, req_b_dest, req_b_data,
        output rsv_valid, rsv_dest, src_one, src_two,
        input  req_a_ready, req_b_ready, busy_one, busy_two,
        input  rf_write_enable, rf_dest, rf_data_in, idle
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter for the register file write port with a one-entry write stage
// and a pending-write scoreboard used by decode to stall on outstanding writes.
module regfile_wb_arbiter (
    input logic               clk,
    input logic               reset,
    regfile_wb_arbiter_if.slave bus
);

    logic        last_grant_a_q;
    logic        last_grant_a_d;
    logic        we_q;
    logic        we_d;
    logic [4:0]  dest_q;
    logic [4:0]  dest_d;
    logic [31:0] data_q;
    logic [31:0] data_d;
    logic [31:0] pending_q;
    logic [31:0] pending_d;
    logic        grant_a;
    logic        grant_b;

    // On a tie the requester that did not win last time gets the port.
    always_comb begin
        grant_a = bus.req_a_valid && (!bus.req_b_valid || !last_grant_a_q);
        grant_b = bus.req_b_valid && (!bus.req_a_valid || last_grant_a_q);
    end

    always_comb begin
        last_grant_a_d = last_grant_a_q;
        we_d           = 1'b0;
        dest_d         = dest_q;
        data_d         = data_q;
        if (grant_a) begin
            last_grant_a_d = 1'b1;
            we_d           = (bus.req_a_dest != 5'd0);
            dest_d         = bus.req_a_dest;
            data_d         = bus.req_a_data;
        end else if (grant_b) begin
            last_grant_a_d = 1'b0;
            we_d           = (bus.req_b_dest != 5'd0);
            dest_d         = bus.req_b_dest;
            data_d         = bus.req_b_data;
        end
    end

    // Clear before set so a same-edge reservation of the retiring register survives.
    always_comb begin
        pending_d = pending_q;
        if (we_q) begin
            pending_d[dest_q] = 1'b0;
        end
        if (bus.rsv_valid && (bus.rsv_dest != 5'd0)) begin
            pending_d[bus.rsv_dest] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant_a_q <= 1'b0;
            we_q           <= 1'b0;
            dest_q         <= 5'd0;
            data_q         <= 32'd0;
            pending_q      <= 32'd0;
        end else begin
            last_grant_a_q <= last_grant_a_d;
            we_q           <= we_d;
            dest_q         <= dest_d;
            data_q         <= data_d;
            pending_q      <= pending_d;
        end
    end

    always_comb begin
        bus.req_a_ready     = grant_a;
        bus.req_b_ready     = grant_b;
        bus.busy_one        = pending_q[bus.src_one];
        bus.busy_two        = pending_q[bus.src_two];
        bus.rf_write_enable = we_q;
        bus.rf_dest         = dest_q;
        bus.rf_data_in      = data_q;
        bus.idle            = (pending_q == 32'd0) && !we_q;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Shares the register file's single write port between two writeback requesters (A: execute result, B: memory load result) using round-robin arbitration and a one-entry registered write stage. It also keeps a 32-entry pending-write scoreboard that decode uses to stall reads of registers with outstanding writes. The block sits between the execute/memory writeback paths and the 32x32 two-read/one-write register file in ID.

## Interface
Parameters:
- none; widths are fixed (5-bit register index, 32-bit data).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- req_a_valid  input  1  requester A has a write
- req_a_dest  input  5  A destination register
- req_a_data  input  32  A write data
- req_a_ready  output  1  A accepted this cycle
- req_b_valid, req_b_dest, req_b_data, req_b_ready  same as A, for requester B
- rsv_valid  input  1  decode reserves a destination for an issuing instruction
- rsv_dest  input  5  reserved register
- src_one  input  5  decode read-port-one index
- src_two  input  5  decode read-port-two index
- busy_one  output  1  src_one has a pending write
- busy_two  output  1  src_two has a pending write
- rf_write_enable  output  1  to register file write enable
- rf_dest  output  5  to register file dest
- rf_data_in  output  32  to register file data_in
- idle  output  1  no pending bits set and write stage empty

## Operation
- Handshake: transfer on the rising edge where valid && ready. Valid must not depend on ready; dest/data held stable while valid && !ready. Ready is combinational from both valids and last_grant.
- Arbitration: only A valid -> grant A; only B valid -> grant B; both valid -> grant the requester not in last_grant, then last_grant updates to the winner. last_grant changes only on a grant.
- Write stage: on a grant, rf_dest/rf_data_in load the winner's dest/data, and rf_write_enable loads 1 if dest != 0, else 0. With no grant, rf_write_enable loads 0 and rf_dest/rf_data_in hold.
- Write stage never back-pressures: the register file accepts every cycle, so the stage drains each cycle.
- x0: dest 0 requests are accepted normally and consume the grant, but produce no write and touch no scoreboard bit.
- Scoreboard pending[31:1] (bit 0 tied 0):
  - set at the edge where rsv_valid && rsv_dest != 0;
  - clear at the edge where rf_write_enable == 1 for rf_dest (the register file captures on that same edge);
  - same-edge set and clear of the same index: set wins.
- busy_one = pending[src_one]; busy_two = pending[src_two]. Combinational; 0 for index 0.
- idle = (pending == 0) && !rf_write_enable.

## Timing
- Reset (async assert, sync-safe deassert) sets rf_write_enable=0, rf_dest=0, rf_data_in=0, pending=0, last_grant=B (A wins the first tie). With no valids, ready outputs are 0; busy_one=busy_two=0; idle=1.
- Reset mid-operation drops the in-flight write and clears all pending bits.
- Latency:
  - request accepted at edge N -> rf_write_enable high during cycle N..N+1 -> register file updated at edge N+1;
  - busy for that register falls after edge N+1, so decode reads the new value in cycle N+1..N+2 (no bypass);
  - reservation at edge M -> busy visible from cycle after M.
- Throughput: one write per cycle. Under continuous dual contention, A and B alternate, and each sees ready at most every other cycle.

## Test plan
- Reset release, no traffic -> all outputs 0 except idle=1; reset mid-write (A accepted, then reset low) -> rf_write_enable=0 and idle=1 immediately.
- Single A write: rsv dest=5, then A valid dest=5 data=0xDEADBEEF -> ready_a=1 same cycle; next cycle rf_write_enable=1, rf_dest=5, rf_data_in=0xDEADBEEF; busy for src_one=5 is 1 until after that edge, then 0.
- Both valid for 4 cycles from reset (A dest=1, B dest=2) -> grants A,B,A,B; each ready high on alternate cycles; rf_dest sequence 1,2,1,2.
- Dest 0: A valid dest=0 data=0x1234 -> ready_a=1, rf_write_enable stays 0, pending unchanged, last_grant=A.
- Same-edge set/clear: pending[7] set, write to 7 in stage while rsv_valid dest=7 -> pending[7] remains 1; busy_two for src_two=7 stays 1 until the second write completes.
- rsv_valid dest=0 -> no pending bit set, busy_one for src_one=0 is 0, idle stays 1.
